dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Dispatch controller for the RN→DP pipeline register of the out-of-order core. It tracks free reservation-station (RS) slots per functional-unit type and free ROB entries, and gates dispatch of the instruction held in the DP register. It drives the `stall` and `flush` inputs of the RN/DP register and sequences branch-mispredict recovery through a small FSM.

## Interface
- `RS_DEPTH`, 4: RS entries per FU type (1..15).
- `ROB_DEPTH`, 2**`ROB_ENTRY_WIDTH`: ROB entries.
- `RECOVER_CYCLES`, 2: cycles of forced stall after a flush (≥1).
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `EN`  in  1  global enable; when low all state holds.
- `FUType_DP`  in  3  FU type of the DP-stage instruction; 0 = bubble, 1..4 = FU types (ALU, MEM, BRA, MUL); 5..7 are treated as bubble.
- `rs_release`  in  4  bit i pulses when FU type i+1 frees one RS entry; any combination per cycle.
- `rob_commit`  in  1  one ROB entry retired this cycle.
- `mispredict`  in  1  branch mispredict signalled at commit; flushes the whole backend.
- `stall`  out  1  to RN/DP `stall` and upstream stages.
- `flush`  out  1  to RN/DP `flush`.
- `dispatch_fire`  out  1  the DP instruction is accepted this cycle.
- `dispatch_fu`  out  4  one-hot FU type of the fired instruction; 0 when not firing.
- `rob_free_cnt`  out  `ROB_ENTRY_WIDTH`+1  free ROB entries.
- `recovering`  out  1  FSM is in FLUSH or RECOVER.
- `err`  out  1  sticky counter over/underflow flag.

## Operation
- Per-type counters `rs_free[1..4]` (4 bits each) and `rob_free` (`ROB_ENTRY_WIDTH`+1 bits).
- `dp_valid` = `FUType_DP` in 1..4.
- Block condition: `rs_free[FUType_DP]`==0 or `rob_free`==0.
- FSM states and outputs:
  - RUN: `stall` = `dp_valid` && block; `flush`=0.
  - FLUSH: `flush`=1, `stall`=0. The RN/DP register gives `stall` priority over `flush`, so `stall` must be low here.
  - RECOVER: `stall`=1, `flush`=0. A down-counter loads `RECOVER_CYCLES`-1 on entry.
- Transitions:
  - RUN→FLUSH on `mispredict`.
  - FLUSH→RECOVER unconditionally.
  - RECOVER→RUN when the counter is 0 and there is no `mispredict`.
  - `mispredict` in any state goes to FLUSH (restarts recovery).
- `dispatch_fire` = RUN && `dp_valid` && !block && !`mispredict`. `dispatch_fu` = one-hot of `FUType_DP` when firing.
- Counter update each enabled cycle in RUN with no `mispredict`:
  - `rs_free[t]` += `rs_release[t-1]` − (fire && type==t).
  - `rob_free` += `rob_commit` − fire.
  - Fire and release/commit of the same type in one cycle leaves the counter unchanged.
- On a cycle where `mispredict` is sampled: all `rs_free` load `RS_DEPTH` and `rob_free` loads `ROB_DEPTH`. Releases and commits in that cycle and during FLUSH/RECOVER are ignored.
- Overflow (release at `RS_DEPTH`, commit at `ROB_DEPTH`): the counter saturates and `err` sets. Underflow cannot occur because fire is blocked at 0.
- `recovering` = state != RUN.
- `EN`=0: FSM, counters and `err` hold. Outputs stay combinational from the held state: `dispatch_fire`=0, `flush` and `stall` are unchanged.

## Timing
- Reset (`rst` sampled high): state RUN, `rs_free`=`RS_DEPTH`, `rob_free`=`ROB_DEPTH`, `err`=0.
  - Outputs after reset: `stall`=0, `flush`=0, `dispatch_fire`=0, `dispatch_fu`=0, `rob_free_cnt`=`ROB_DEPTH`, `recovering`=0.
- `rst` overrides `EN` and `mispredict`. Reset mid-recovery returns to RUN the next cycle.
- `stall`, `dispatch_fire` and `dispatch_fu` are combinational from the current state and `FUType_DP`. Counters update at the next edge.
- A release in cycle N unblocks a stalled instruction in cycle N+1: zero-bubble reuse, but no same-cycle bypass.
- `mispredict` in cycle N gives FLUSH in N+1 and RECOVER in N+2..N+1+`RECOVER_CYCLES`. RUN resumes at N+2+`RECOVER_CYCLES`.
- A `mispredict` in cycle N suppresses `dispatch_fire` in cycle N.

## Test plan
- Reset then idle with `FUType_DP`=0 → `stall`=0, `flush`=0, `rob_free_cnt`=16 (`ROB_ENTRY_WIDTH`=4), `dispatch_fu`=0.
- Five consecutive ALU instructions (`FUType_DP`=1), no releases, `RS_DEPTH`=4 → fires in cycles 0–3 with `dispatch_fu`=4'b0001; cycle 4 `stall`=1. Pulse `rs_release`[0] in cycle 5 → fires in cycle 6.
- `rs_free[MEM]`=0 and `rs_release`[1]=1 in the same cycle as a MEM instruction in DP → `stall`=1 that cycle, fire the next cycle. Separately, an ALU fire plus `rs_release`[0] in one cycle → `rs_free[ALU]` unchanged.
- Fill the ROB with 16 fires across mixed types and releases → `rob_free_cnt`=0 and `stall`=1. One `rob_commit` → fire the next cycle, `rob_free_cnt` stays 0.
- `mispredict` in cycle 10 with `RECOVER_CYCLES`=2 → `flush`=1 in cycle 11, `stall`=1 in cycles 12–13, RUN in cycle 14 with all counters full. A second `mispredict` in cycle 12 restarts: FLUSH in cycle 13.
- `rs_release`[2] while `rs_free[BRA]`=4 → counter stays 4 and `err`=1, held until `rst`. `EN`=0 for 3 cycles mid-test → all counters and state frozen.

Source files
------------

// File: rtl/dispatch_ctrl_if.sv
// Dispatch-stage interface between the RN/DP pipeline side and dispatch_ctrl.
//   master : pipeline side; drives the DP instruction type, RS releases, ROB commits and mispredicts,
//            and observes stall/flush/fire plus the status outputs.
//   slave  : dispatch_ctrl; the reverse directions.
interface dispatch_ctrl_if #(
  parameter int unsigned ROB_ENTRY_WIDTH = 4
);
  logic [2:0]               FUType_DP;
  logic [3:0]               rs_release;
  logic                     rob_commit;
  logic                     mispredict;
  logic                     stall;
  logic                     flush;
  logic                     dispatch_fire;
  logic [3:0]               dispatch_fu;
  logic [ROB_ENTRY_WIDTH:0] rob_free_cnt;
  logic                     recovering;
  logic                     err;

  modport master (
    output FUType_DP, rs_release, rob_commit, mispredict,
    input  stall, flush, dispatch_fire, dispatch_fu, rob_free_cnt, recovering, err
  );

  modport slave (
    input  FUType_DP, rs_release, rob_commit, mispredict,
    output stall, flush, dispatch_fire, dispatch_fu, rob_free_cnt, recovering, err
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch controller for the RN->DP pipeline register.
// Tracks free RS slots per FU type (ALU, MEM, BRA, MUL) and free ROB entries, gates dispatch of
// the DP-stage instruction, and sequences mispredict recovery (RUN -> FLUSH -> RECOVER -> RUN).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   EN       : global enable; when low all state holds and nothing fires
//   dp       : dispatch_ctrl_if slave (FUType_DP, rs_release, rob_commit, mispredict in;
//              stall, flush, dispatch_fire, dispatch_fu, rob_free_cnt, recovering, err out)
// stall, dispatch_fire and dispatch_fu are combinational from state and FUType_DP;
// flush, rob_free_cnt, recovering and err come straight from registered state.
module dispatch_ctrl #(
  parameter int unsigned RS_DEPTH        = 4,
  parameter int unsigned ROB_ENTRY_WIDTH = 4,
  parameter int unsigned RECOVER_CYCLES  = 2
) (
  input logic            clk,
  input logic            rst,
  input logic            EN,
  dispatch_ctrl_if.slave dp
);

  localparam int unsigned NUM_FU    = 4;
  localparam int unsigned RS_W      = 4;
  localparam int unsigned ROB_W     = ROB_ENTRY_WIDTH + 1;
  localparam int unsigned ROB_DEPTH = 1 << ROB_ENTRY_WIDTH;
  localparam int unsigned RC_W      = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [RC_W-1:0]              rc_q, rc_d;
  logic [NUM_FU-1:0][RS_W-1:0]  rs_free_q, rs_free_d;
  logic [ROB_W-1:0]             rob_free_q, rob_free_d;
  logic                         err_q, err_d;

  logic [NUM_FU-1:0]            fu_oh_c;
  logic                         dp_valid_c;
  logic [RS_W-1:0]              sel_free_c;
  logic                         block_c;
  logic                         stall_c;
  logic                         flush_c;
  logic                         fire_c;

  // State, recovery counter, credit counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      rc_q       <= '0;
      rs_free_q  <= {NUM_FU{RS_W'(RS_DEPTH)}};
      rob_free_q <= ROB_W'(ROB_DEPTH);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      rs_free_q  <= rs_free_d;
      rob_free_q <= rob_free_d;
      err_q      <= err_d;
    end
  end

  // Decode, dispatch gating, FSM outputs and next-state / counter updates.
  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    rs_free_d  = rs_free_q;
    rob_free_d = rob_free_q;
    err_d      = err_q;
    fu_oh_c    = '0;
    sel_free_c = '0;
    stall_c    = 1'b0;
    flush_c    = 1'b0;
    fire_c     = 1'b0;

    // Types 5..7 decode to no one-hot bit and therefore behave as bubbles.
    case (dp.FUType_DP)
      3'd1:    fu_oh_c = 4'b0001;
      3'd2:    fu_oh_c = 4'b0010;
      3'd3:    fu_oh_c = 4'b0100;
      3'd4:    fu_oh_c = 4'b1000;
      default: fu_oh_c = 4'b0000;
    endcase
    dp_valid_c = |fu_oh_c;

    for (int t = 0; t < NUM_FU; t++) begin
      if (fu_oh_c[t]) sel_free_c = rs_free_q[t];
    end
    block_c = (sel_free_c == '0) || (rob_free_q == '0);

    case (state_q)
      ST_RUN: begin
        stall_c = dp_valid_c && block_c;
        fire_c  = EN && dp_valid_c && !block_c && !dp.mispredict;
      end
      ST_FLUSH: begin
        // The RN/DP register lets stall win over flush, so stall must stay low here.
        flush_c = 1'b1;
      end
      ST_RECOVER: begin
        stall_c = 1'b1;
      end
      default: begin
        stall_c = 1'b0;
      end
    endcase

    if (EN) begin
      if (dp.mispredict) begin
        // Whole backend is flushed: every resource becomes free, same-cycle releases are moot.
        state_d    = ST_FLUSH;
        rs_free_d  = {NUM_FU{RS_W'(RS_DEPTH)}};
        rob_free_d = ROB_W'(ROB_DEPTH);
      end else begin
        case (state_q)
          ST_RUN: begin
            for (int t = 0; t < NUM_FU; t++) begin
              if (dp.rs_release[t] && !(fire_c && fu_oh_c[t])) begin
                if (rs_free_q[t] == RS_W'(RS_DEPTH)) err_d = 1'b1;
                else rs_free_d[t] = rs_free_q[t] + RS_W'(1);
              end else if (!dp.rs_release[t] && fire_c && fu_oh_c[t]) begin
                rs_free_d[t] = rs_free_q[t] - RS_W'(1);
              end
            end
            if (dp.rob_commit && !fire_c) begin
              if (rob_free_q == ROB_W'(ROB_DEPTH)) err_d = 1'b1;
              else rob_free_d = rob_free_q + ROB_W'(1);
            end else if (!dp.rob_commit && fire_c) begin
              rob_free_d = rob_free_q - ROB_W'(1);
            end
          end
          ST_FLUSH: begin
            state_d = ST_RECOVER;
            rc_d    = RC_W'(RECOVER_CYCLES - 1);
          end
          ST_RECOVER: begin
            if (rc_q == '0) state_d = ST_RUN;
            else rc_d = rc_q - RC_W'(1);
          end
          default: begin
            state_d = ST_RUN;
          end
        endcase
      end
    end
  end

  assign dp.stall         = stall_c;
  assign dp.flush         = flush_c;
  assign dp.dispatch_fire = fire_c;
  assign dp.dispatch_fu   = fire_c ? fu_oh_c : 4'b0000;
  assign dp.rob_free_cnt  = rob_free_q;
  assign dp.recovering    = (state_q != ST_RUN);
  assign dp.err           = err_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl (RS_DEPTH=4, ROB_ENTRY_WIDTH=4, RECOVER_CYCLES=2).
// Inputs change 1 time unit after each rising edge; outputs are sampled 2 units later.
module tb_dispatch_ctrl;

  logic clk;
  logic rst;
  logic EN;
  int   n_checks;
  int   n_fail;

  dispatch_ctrl_if #(.ROB_ENTRY_WIDTH(4)) dp_if ();

  dispatch_ctrl #(
    .RS_DEPTH       (4),
    .ROB_ENTRY_WIDTH(4),
    .RECOVER_CYCLES (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .EN (EN),
    .dp (dp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply DP-side inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic [2:0] fu, input logic [3:0] rel, input logic commit, input logic mp);
    dp_if.FUType_DP  = fu;
    dp_if.rs_release = rel;
    dp_if.rob_commit = commit;
    dp_if.mispredict = mp;
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    EN  = 1'b1;
    dp_if.FUType_DP  = 3'd0;
    dp_if.rs_release = 4'b0;
    dp_if.rob_commit = 1'b0;
    dp_if.mispredict = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state, idle bubble.
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rst_stall", 32'(dp_if.stall), 0);
    check("rst_flush", 32'(dp_if.flush), 0);
    check("rst_rob", 32'(dp_if.rob_free_cnt), 16);
    check("rst_fu", 32'(dp_if.dispatch_fu), 0);
    check("rst_fire", 32'(dp_if.dispatch_fire), 0);
    check("rst_recov", 32'(dp_if.recovering), 0);
    check("rst_err", 32'(dp_if.err), 0);
    tick();

    // Five ALU instructions: four fire, fifth stalls.
    for (int i = 0; i < 4; i++) begin
      drive(3'd1, 4'b0, 1'b0, 1'b0);
      check("alu_fire", 32'(dp_if.dispatch_fire), 1);
      check("alu_fu", 32'(dp_if.dispatch_fu), 1);
      tick();
    end
    drive(3'd1, 4'b0, 1'b0, 1'b0);
    check("alu_stall", 32'(dp_if.stall), 1);
    check("alu_nofire", 32'(dp_if.dispatch_fire), 0);
    tick();
    // Release in this cycle: no same-cycle bypass.
    drive(3'd1, 4'b0001, 1'b0, 1'b0);
    check("alu_rel_stall", 32'(dp_if.stall), 1);
    tick();
    drive(3'd1, 4'b0, 1'b0, 1'b0);
    check("alu_rel_fire", 32'(dp_if.dispatch_fire), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rob_after_alu", 32'(dp_if.rob_free_cnt), 11);

    // Drain MEM credits, then release in the same cycle as a blocked MEM.
    for (int i = 0; i < 4; i++) begin
      drive(3'd2, 4'b0, 1'b0, 1'b0);
      check("mem_fire", 32'(dp_if.dispatch_fu), 2);
      tick();
    end
    drive(3'd2, 4'b0010, 1'b0, 1'b0);
    check("mem_rel_stall", 32'(dp_if.stall), 1);
    check("mem_rel_nofire", 32'(dp_if.dispatch_fire), 0);
    tick();
    drive(3'd2, 4'b0, 1'b0, 1'b0);
    check("mem_next_fire", 32'(dp_if.dispatch_fire), 1);
    tick();

    // ALU is at 0: release once, then fire + release together leaves it at 1.
    drive(3'd0, 4'b0001, 1'b0, 1'b0);
    tick();
    drive(3'd1, 4'b0001, 1'b0, 1'b0);
    check("alu_fr_fire", 32'(dp_if.dispatch_fire), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("alu_fr_cnt", 32'(dut.rs_free_q[0]), 1);
    check("rob_before_fill", 32'(dp_if.rob_free_cnt), 5);

    // Fill the ROB: four BRA and one MUL bring it to 0 (16 fires total).
    for (int i = 0; i < 4; i++) begin
      drive(3'd3, 4'b0, 1'b0, 1'b0);
      check("bra_fire", 32'(dp_if.dispatch_fu), 4);
      tick();
    end
    drive(3'd4, 4'b0, 1'b0, 1'b0);
    check("mul_fire", 32'(dp_if.dispatch_fu), 8);
    tick();
    drive(3'd4, 4'b0, 1'b0, 1'b0);
    check("rob_full_cnt", 32'(dp_if.rob_free_cnt), 0);
    check("rob_full_stall", 32'(dp_if.stall), 1);
    tick();
    drive(3'd4, 4'b0, 1'b1, 1'b0);
    check("rob_commit_stall", 32'(dp_if.stall), 1);
    tick();
    drive(3'd4, 4'b0, 1'b0, 1'b0);
    check("rob_commit_fire", 32'(dp_if.dispatch_fire), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rob_still_zero", 32'(dp_if.rob_free_cnt), 0);
    tick();

    // Free one ROB entry so an ALU would fire, then mispredict suppresses it.
    drive(3'd0, 4'b0, 1'b1, 1'b0);
    tick();
    drive(3'd1, 4'b0, 1'b0, 1'b1);
    check("mp_nofire", 32'(dp_if.dispatch_fire), 0);
    check("mp_nostall", 32'(dp_if.stall), 0);
    tick();
    drive(3'd1, 4'b1111, 1'b1, 1'b0);
    check("mp_flush", 32'(dp_if.flush), 1);
    check("mp_flush_nostall", 32'(dp_if.stall), 0);
    check("mp_flush_recov", 32'(dp_if.recovering), 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(3'd1, 4'b0, 1'b0, 1'b0);
      check("mp_rec_stall", 32'(dp_if.stall), 1);
      check("mp_rec_noflush", 32'(dp_if.flush), 0);
      tick();
    end
    drive(3'd1, 4'b0, 1'b0, 1'b0);
    check("mp_run_recov", 32'(dp_if.recovering), 0);
    check("mp_run_rob", 32'(dp_if.rob_free_cnt), 16);
    check("mp_run_fire", 32'(dp_if.dispatch_fire), 1);
    check("mp_run_err", 32'(dp_if.err), 0);
    tick();

    // Mispredict during RECOVER restarts at FLUSH.
    drive(3'd0, 4'b0, 1'b0, 1'b1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rs_flush1", 32'(dp_if.flush), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b1);
    check("rs_rec1", 32'(dp_if.stall), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rs_flush2", 32'(dp_if.flush), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rs_rec2a", 32'(dp_if.stall), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rs_rec2b", 32'(dp_if.recovering), 1);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rs_run", 32'(dp_if.recovering), 0);
    tick();

    // BRA release while full: saturates and sets err.
    drive(3'd0, 4'b0100, 1'b0, 1'b0);
    tick();
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("ovf_err", 32'(dp_if.err), 1);
    check("ovf_bra_cnt", 32'(dut.rs_free_q[2]), 4);
    tick();
    drive(3'd1, 4'b0, 1'b0, 1'b0);
    tick();

    // EN low for three cycles: nothing moves despite busy inputs.
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 4'b1111, 1'b1, 1'b1);
      check("en_nofire", 32'(dp_if.dispatch_fire), 0);
      check("en_rob", 32'(dp_if.rob_free_cnt), 15);
      check("en_recov", 32'(dp_if.recovering), 0);
      tick();
    end
    EN = 1'b1;
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("en_after_rob", 32'(dp_if.rob_free_cnt), 15);
    check("en_after_alu", 32'(dut.rs_free_q[0]), 3);
    check("en_after_flush", 32'(dp_if.flush), 0);
    check("err_sticky", 32'(dp_if.err), 1);
    tick();

    // Reset clears err.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(3'd0, 4'b0, 1'b0, 1'b0);
    check("rst2_err", 32'(dp_if.err), 0);
    check("rst2_rob", 32'(dp_if.rob_free_cnt), 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
